// File: rtl/polar_arb_pkg.sv
// Shared constants and the tag type for the shared Cartesian-to-polar core front end.
package polar_arb_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int W_DEF        = 32;
  localparam int CORE_LAT_DEF = 18;

  // Tag ids are sized for the largest supported requester count (16) and zero-extended.
  localparam int IDW_MAX = 4;

  typedef struct packed {
    logic               vld;
    logic [IDW_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/polar_share_arb_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic           gnt_vld_o,
  output logic [IDW-1:0] idx_o
);

  int             k;
  logic [IDW-1:0] k_idx;

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    idx_o     = '0;
    k         = 0;
    k_idx     = '0;
    for (int i = 0; i < N; i++) begin
      k     = (int'(ptr_i) + i) % N;
      k_idx = IDW'(k);
      if (!gnt_vld_o && req_i[k_idx]) begin
        gnt_vld_o    = 1'b1;
        gnt_o[k_idx] = 1'b1;
        idx_o        = k_idx;
      end
    end
  end

endmodule

// File: rtl/polar_share_arb.sv
// Shares one fixed-latency Cartesian-to-polar core among N_REQ requesters and
// returns each result tagged with the requester that issued it.
module polar_share_arb
  import polar_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int W        = W_DEF,
  parameter int CORE_LAT = CORE_LAT_DEF,
  parameter int IDW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_vld,
  output logic [N_REQ-1:0]   req_rdy,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic               core_vld,
  output logic [W-1:0]       core_x,
  output logic [W-1:0]       core_y,
  input  logic               core_o_vld,
  input  logic [W-1:0]       core_mag,
  input  logic [W-1:0]       core_phase,
  output logic               res_vld,
  output logic [IDW-1:0]     res_id,
  output logic [W-1:0]       res_mag,
  output logic [W-1:0]       res_phase,
  output logic               busy,
  output logic               err_align
);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic             grant_en;

  logic             core_vld_q;
  logic [W-1:0]     core_x_q, core_y_q;
  logic [IDW-1:0]   issue_id_q;

  tag_t             tag_q [CORE_LAT];
  tag_t             head;
  logic             tag_busy;

  logic             res_vld_q;
  logic [IDW-1:0]   res_id_q;
  logic [W-1:0]     res_mag_q, res_phase_q;
  logic             err_q;

  assign grant_en = en & ~rst;

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
    .req_i     (req_vld & {N_REQ{grant_en}}),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld),
    .idx_o     (gnt_idx)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      core_vld_q <= 1'b0;
      core_x_q   <= '0;
      core_y_q   <= '0;
      issue_id_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      core_vld_q <= gnt_vld;
      if (gnt_vld) begin
        core_x_q   <= req_x[int'(gnt_idx)*W +: W];
        core_y_q   <= req_y[int'(gnt_idx)*W +: W];
        issue_id_q <= gnt_idx;
      end
    end
  end

  // NOTE: the tag line is reset in full so a reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CORE_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0].vld <= core_vld_q;
      tag_q[0].id  <= IDW_MAX'(issue_id_q);
      for (int i = 1; i < CORE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The last stage lines up with the core's output valid.
  assign head = tag_q[CORE_LAT-1];

  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i < CORE_LAT; i++) tag_busy = tag_busy | tag_q[i].vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_q   <= 1'b0;
      res_id_q    <= '0;
      res_mag_q   <= '0;
      res_phase_q <= '0;
      err_q       <= 1'b0;
    end else begin
      res_vld_q   <= core_o_vld;
      res_id_q    <= head.vld ? head.id[IDW-1:0] : '0;
      res_mag_q   <= core_mag;
      res_phase_q <= core_phase;
      err_q       <= err_q | (core_o_vld != head.vld);
    end
  end

  assign req_rdy   = gnt;
  assign core_vld  = core_vld_q;
  assign core_x    = core_x_q;
  assign core_y    = core_y_q;
  assign res_vld   = res_vld_q;
  assign res_id    = res_id_q;
  assign res_mag   = res_mag_q;
  assign res_phase = res_phase_q;
  assign busy      = core_vld_q | tag_busy;
  assign err_align = err_q;

endmodule

// File: tb/tb_polar_share_arb.sv
// Directed bench for polar_share_arb with a pass-through core model (mag=x, phase=y).
module tb_polar_share_arb;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 18;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst, en;
  logic [N-1:0]     req_vld, req_rdy;
  logic [N*W-1:0]   req_x, req_y;
  logic             core_vld, core_o_vld;
  logic [W-1:0]     core_x, core_y, core_mag, core_phase;
  logic             res_vld, busy, err_align;
  logic [IDW-1:0]   res_id;
  logic [W-1:0]     res_mag, res_phase;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_res = 0;
  int n0;
  bit sb_en = 1'b1;
  int core_lat_sel = LAT;

  typedef struct {
    int         id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  polar_share_arb #(.N_REQ(N), .W(W), .CORE_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_x      (req_x),
    .req_y      (req_y),
    .core_vld   (core_vld),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_o_vld (core_o_vld),
    .core_mag   (core_mag),
    .core_phase (core_phase),
    .res_vld    (res_vld),
    .res_id     (res_id),
    .res_mag    (res_mag),
    .res_phase  (res_phase),
    .busy       (busy),
    .err_align  (err_align)
  );

  // Core model: latency selectable so a misaligned core can be emulated.
  logic [LAT-1:0] cm_vld;
  logic [W-1:0]   cm_x [LAT];
  logic [W-1:0]   cm_y [LAT];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) cm_vld <= '0;
    else     cm_vld <= {cm_vld[LAT-2:0], core_vld};
    cm_x[0] <= core_x;
    cm_y[0] <= core_y;
    for (int i = 1; i < LAT; i++) begin
      cm_x[i] <= cm_x[i-1];
      cm_y[i] <= cm_y[i-1];
    end
  end

  assign core_o_vld = cm_vld[core_lat_sel-1];
  assign core_mag   = cm_x[core_lat_sel-1];
  assign core_phase = cm_y[core_lat_sel-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: handshakes queue expectations, results must match in order and latency.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (res_vld) begin
        n_res++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            check("res_unexpected", 64'(res_vld), 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("res_id", 64'(res_id), 64'(e.id));
            check("res_mag", 64'(res_mag), 64'(e.x));
            check("res_phase", 64'(res_phase), 64'(e.y));
            check("res_lat", 64'(cyc - e.cyc), 64'(LAT + 2));
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (req_vld[k] && req_rdy[k]) begin
          exp_t e;
          e.id  = k;
          e.x   = req_x[k*W +: W];
          e.y   = req_y[k*W +: W];
          e.cyc = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    req_vld = '0;
    for (int k = 0; k < N; k++) begin
      req_x[k*W +: W] = W'((k + 1) << 10);
      req_y[k*W +: W] = W'(1 << 10);
    end
    repeat (3) tick();

    // Reset state: no grant while rst is high, all registered outputs zero.
    en = 1'b1;
    req_vld = 4'b1111;
    #1 check("rst_rdy", 64'(req_rdy), 64'd0);
    req_vld = '0;
    check("rst_res_vld", 64'(res_vld), 64'd0);
    check("rst_core_vld", 64'(core_vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_align), 64'd0);
    rst = 1'b0;
    tick();

    // 1: all valid, grants rotate 0,1,2,3,0,1,2,3.
    req_vld = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 check("t1_rdy", 64'(req_rdy), 64'(4'b0001 << (c % 4)));
      tick();
    end
    req_vld = '0;
    repeat (24) tick();
    check("t1_nres", 64'(n_res), 64'd8);
    check("t1_err", 64'(err_align), 64'd0);

    // 2: single requester granted every cycle; ptr ends at 3.
    for (int k = 0; k < N; k++) begin
      req_x[k*W +: W] = W'(32'h1000 * (k + 1) + 5);
      req_y[k*W +: W] = W'(32'h0100 * (k + 1) + 7);
    end
    req_vld = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1 check("t2_rdy", 64'(req_rdy), 64'b0100);
      tick();
    end
    req_vld = 4'b1111;
    #1 check("t2_ptr3", 64'(req_rdy), 64'b1000);

    // 3: move ptr to 2, then 1 and 3 alternate; 3 drops and 1 takes every cycle.
    req_vld = 4'b0010;
    #1 check("t3_pre", 64'(req_rdy), 64'b0010);
    tick();
    req_vld = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1 check("t3_alt", 64'(req_rdy), (c % 2 == 0) ? 64'b1000 : 64'b0010);
      tick();
    end
    req_vld = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1 check("t3_solo", 64'(req_rdy), 64'b0010);
      tick();
    end
    req_vld = '0;
    repeat (24) tick();
    check("t3_nres", 64'(n_res), 64'd21);

    // 4: two grants (2,3), then en low for 3 cycles; busy falls 19 cycles after last issue.
    req_vld = 4'b1111;
    #1 check("t4_g2", 64'(req_rdy), 64'b0100);
    tick();
    #1 check("t4_g3", 64'(req_rdy), 64'b1000);
    tick();
    en = 1'b0;
    #1 check("t4_rdy_off", 64'(req_rdy), 64'd0);
    check("t4_last_issue", 64'(core_vld), 64'd1);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("t4_rdy_off", 64'(req_rdy), 64'd0);
      check("t4_no_issue", 64'(core_vld), 64'd0);
    end
    req_vld = '0;
    repeat (16) tick();
    check("t4_busy_hi", 64'(busy), 64'd1);
    tick();
    check("t4_busy_lo", 64'(busy), 64'd0);
    en = 1'b1;
    req_vld = 4'b1111;
    #1 check("t4_ptr_held", 64'(req_rdy), 64'b0001);
    req_vld = '0;
    repeat (3) tick();
    check("t4_nres", 64'(n_res), 64'd23);
    repeat (3) tick();

    // 5: core one cycle short; err_align goes sticky, result emitted with id 0.
    sb_en = 1'b0;
    core_lat_sel = LAT - 1;
    req_vld = 4'b0001;
    #1 check("t5_rdy", 64'(req_rdy), 64'b0001);
    tick();
    req_vld = '0;
    check("t5_issue", 64'(core_vld), 64'd1);
    repeat (17) tick();
    check("t5_err_pre", 64'(err_align), 64'd0);
    tick();
    check("t5_err_set", 64'(err_align), 64'd1);
    check("t5_res_vld", 64'(res_vld), 64'd1);
    check("t5_res_id", 64'(res_id), 64'd0);
    repeat (6) tick();
    check("t5_err_sticky", 64'(err_align), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_err_clr", 64'(err_align), 64'd0);
    core_lat_sel = LAT;
    tick();
    sb_en = 1'b1;

    // 6: reset 5 cycles after issuing 4 samples drops them all.
    req_vld = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1 check("t6_rdy", 64'(req_rdy), 64'(4'b0001 << c));
      tick();
    end
    req_vld = '0;
    repeat (5) tick();
    rst = 1'b1;
    req_vld = 4'b1111;
    #1 check("t6_rst_rdy", 64'(req_rdy), 64'd0);
    req_vld = '0;
    tick();
    check("t6_res_vld", 64'(res_vld), 64'd0);
    check("t6_res_id", 64'(res_id), 64'd0);
    check("t6_res_mag", 64'(res_mag), 64'd0);
    check("t6_res_phase", 64'(res_phase), 64'd0);
    check("t6_core_vld", 64'(core_vld), 64'd0);
    check("t6_core_x", 64'(core_x), 64'd0);
    check("t6_core_y", 64'(core_y), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_err", 64'(err_align), 64'd0);
    rst = 1'b0;
    n0 = n_res;
    repeat (30) tick();
    check("t6_no_results", 64'(n_res), 64'(n0));
    check("t6_err_end", 64'(err_align), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/polar_share_arb.md
Name: polar_share_arb

Overview:
Shares one pipelined Cartesian-to-polar core (`topolar`: `clk`, `rst`, `i_vld`/`i_x`/`i_y` in; `o_vld`/`o_mag`/`o_phase` out, fixed latency, no backpressure) between N_REQ requesters, for example per-channel FFT bin streams.
- Round-robin arbitration: at most one issue per cycle.
- Each issued sample carries a requester-ID tag down a delay line matched to the core latency.
- Results are returned on one tagged output stream.
- A sticky alignment check flags a mismatch between the tag line and the core's valid.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- W, 32, signed sample width of x, y, mag, phase
- CORE_LAT, 18, core latency in cycles from `i_vld` to `o_vld` (≥1)
- IDW, $clog2(N_REQ), width of the requester ID

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset; the same net also resets the core
- en  in  1  grant enable; when low, no new grants are made and in-flight samples drain
- req_vld  in  N_REQ  per-requester sample valid
- req_rdy  out  N_REQ  per-requester accept, one-hot or zero
- req_x  in  N_REQ*W  packed signed x, requester k at [k*W +: W]
- req_y  in  N_REQ*W  packed signed y, same packing as req_x
- core_vld  out  1  to core `i_vld`
- core_x  out  W  to core `i_x`
- core_y  out  W  to core `i_y`
- core_o_vld  in  1  from core `o_vld`
- core_mag  in  W  from core `o_mag`
- core_phase  in  W  from core `o_phase`
- res_vld  out  1  result valid
- res_id  out  IDW  requester that issued this result
- res_mag  out  W  magnitude
- res_phase  out  W  phase
- busy  out  1  core_vld is set or any tag-line stage is valid
- err_align  out  1  sticky alignment error

Behaviour:
- Reset values: all outputs 0; round-robin pointer ptr=0; tag line cleared. Reset mid-operation drops all in-flight tags; no results are produced afterwards for samples issued before reset.
- Grant (combinational):
  - Active only when en=1 and rst=0.
  - Selects the first k with req_vld[k]=1, searching ptr, ptr+1, …, wrapping modulo N_REQ.
  - req_rdy[k]=1 for the granted k only.
  - req_rdy may depend on req_vld. Requesters must not make req_vld depend on req_rdy.
- Handshake: the sample transfers in the cycle t where req_vld[k]=req_rdy[k]=1.
- Pointer update: after a grant to k, ptr ← (k+1) mod N_REQ. With no grant, ptr holds.
- Issue register:
  - At t+1: core_vld=1, core_x/core_y = the granted sample.
  - Otherwise core_vld=0; core_x/core_y hold their last value.
- Tag line:
  - CORE_LAT stages of {vld, id}.
  - Stage 0 loads {core_vld, id of the sample on core_x/core_y}.
  - The head stage is aligned with core_o_vld.
- Result register (registered, one cycle after core_o_vld):
  - res_vld ← core_o_vld
  - res_mag ← core_mag
  - res_phase ← core_phase
  - res_id ← head id, or 0 if head vld=0
- End-to-end latency: handshake at t gives res_vld at t+CORE_LAT+2.
- Throughput: one sample per cycle. With all requesters valid, grants rotate 0,1,…,N_REQ−1,0,…
- Alignment check:
  - Any cycle with core_o_vld ≠ head vld sets err_align.
  - err_align is cleared only by rst.
  - The result is still emitted if core_o_vld=1.
- en falling mid-stream: no grant that cycle. Already-issued samples complete and busy deasserts CORE_LAT+1 cycles after the last issue. ptr is held.
- Requester dropping req_vld while another holds it: no effect on fairness; the pointer only moves on a grant.
- Single requester: granted every cycle it is valid.

Decomposition:
- Package polar_arb_pkg:
  - default constants N_REQ_DEF, W_DEF, CORE_LAT_DEF
  - typedef tag_t {logic vld; logic [IDW-1:0] id;}
- One sub-module rr_arbiter(N): req vector, ptr → one-hot grant and encoded index.
- The tag delay line is an inline shift register.
- The core is instantiated outside this block.

Test Plan:
1. After reset, hold req_vld=4'b1111 with distinct samples (k: x=(k+1)<<10, y=1<<10) for 8 cycles → grant order 0,1,2,3,0,1,2,3. res_id follows the same order starting 20 cycles after the first handshake. err_align=0.
2. Only requester 2 valid for 5 cycles → req_rdy=4'b0100 every cycle. Five results with res_id=2 back-to-back. ptr=3 afterwards.
3. Requesters 1 and 3 valid with ptr=2 → order 3,1,3,1. Requester 3 drops mid-run → requester 1 is granted every following cycle.
4. en=0 for 3 cycles with all valid → req_rdy=0 and no core_vld. Samples in flight still complete. busy falls 19 cycles after the last issue.
5. Core model with latency 17 instead of 18, one sample issued → err_align=1 at the mismatch and stays 1. After rst, err_align=0.
6. Assert rst 5 cycles after issuing 4 samples → no res_vld for those samples, and all outputs read 0 the cycle after rst.
